// File: rtl/res_collector_pkg.sv
// Shared defaults and types for the result collector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package res_collector_pkg;

    localparam int RES_WIDTH_DEF = 8;
    localparam int NUM_DEF       = 100;
    localparam int DROP_W        = 16;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/res_collector_if.sv
// Handshake/bus bundle between the adder stage, the collector and the package consumer.
// Latency: n/a (wiring only).
// Backpressure: pkg_ready_i from the consumer; csum_o only when RES_COLLECTOR_CSUM_EN is defined.
interface res_collector_if
    import res_collector_pkg::*;
#(
    parameter int RES_WIDTH     = RES_WIDTH_DEF,
    parameter int NUM           = NUM_DEF,
    parameter int PACKAGE_WIDTH = RES_WIDTH * NUM
);
    logic [RES_WIDTH-1:0]     res_i;
    logic                     res_valid_i;
    logic                     flush_i;
    logic [PACKAGE_WIDTH-1:0] pkg_o;
    logic                     pkg_valid_o;
    logic                     pkg_ready_i;
    logic [7:0]               count_o;
    logic [DROP_W-1:0]        drop_o;
`ifdef RES_COLLECTOR_CSUM_EN
    logic [15:0]              csum_o;
`endif

    // Producer/consumer side driving the collector.
    modport master (
        output res_i, res_valid_i, flush_i, pkg_ready_i,
        input  pkg_o, pkg_valid_o, count_o, drop_o
`ifdef RES_COLLECTOR_CSUM_EN
        , input csum_o
`endif
    );

    // Collector side.
    modport slave (
        input  res_i, res_valid_i, flush_i, pkg_ready_i,
        output pkg_o, pkg_valid_o, count_o, drop_o
`ifdef RES_COLLECTOR_CSUM_EN
        , output csum_o
`endif
    );

endinterface

// File: rtl/res_collector_csum.sv
// Running modulo-2^16 sum of the words accepted into the current package.
// Latency: 1 cycle from accept to updated csum_o.
// Backpressure: none; follows the collector's accept/clear strobes.
module res_collector_csum #(
    parameter int RES_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 clr_i,
    input  logic                 add_i,
    input  logic [RES_WIDTH-1:0] word_i,
    output logic [15:0]          csum_o
);

    logic [15:0] sum_q;
    logic [15:0] base;
    logic [15:0] addend;

    // A clear and an add in the same cycle restart the sum at the new word.
    always_comb begin
        base   = clr_i ? 16'd0 : sum_q;
        addend = add_i ? 16'(word_i) : 16'd0;
    end

    // Accumulator register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) sum_q <= 16'd0;
        else           sum_q <= base + addend;
    end

    assign csum_o = sum_q;

endmodule

// File: rtl/res_collector.sv
// Packs NUM adder results into one wide package and holds it for the consumer (RES_COLLECTOR_CSUM_EN adds csum_o).
// Latency: pkg_valid_o rises 1 cycle after the NUMth accept or a flush.
// Backpressure: package held until pkg_ready_i; words arriving while held without ready are dropped and counted.
module res_collector
    import res_collector_pkg::*;
#(
    parameter int RES_WIDTH     = RES_WIDTH_DEF,
    parameter int NUM           = NUM_DEF,
    parameter int PACKAGE_WIDTH = RES_WIDTH * NUM
) (
    input logic            clk_i,
    input logic            reset_ni,
    res_collector_if.slave bus
);

    localparam logic [7:0] LAST = 8'(NUM - 1);

    state_t                   state_q, state_d;
    logic [PACKAGE_WIDTH-1:0] pkg_q, pkg_d;
    logic [7:0]               count_q, count_d;
    logic [DROP_W-1:0]        drop_q, drop_d;
    logic                     accept;
    logic                     release_pkg;

    // State register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= FILL;
        else           state_q <= state_d;
    end

    // Next state plus accept/release strobes; a word arriving with ready in HOLD opens the next package.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        release_pkg = 1'b0;
        case (state_q)
            FILL: begin
                accept = bus.res_valid_i;
                if (accept && count_q == LAST)
                    state_d = HOLD;
                else if (bus.flush_i && (count_q != 8'd0 || bus.res_valid_i))
                    state_d = HOLD;
            end
            HOLD: begin
                release_pkg = bus.pkg_ready_i;
                accept      = bus.pkg_ready_i && bus.res_valid_i;
                if (bus.pkg_ready_i)
                    state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    // Package, slot count and drop counter updates; release clears before the new word lands in slot 0.
    always_comb begin
        pkg_d   = release_pkg ? '0 : pkg_q;
        count_d = release_pkg ? 8'd0 : count_q;
        drop_d  = drop_q;
        if (accept) begin
            for (int k = 0; k < NUM; k++) begin
                if (count_d == 8'(k))
                    pkg_d[k*RES_WIDTH +: RES_WIDTH] = bus.res_i;
            end
            count_d = count_d + 8'd1;
        end
        if (state_q == HOLD && !bus.pkg_ready_i && bus.res_valid_i && drop_q != '1)
            drop_d = drop_q + 1'b1;
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pkg_q   <= '0;
            count_q <= 8'd0;
            drop_q  <= '0;
        end else begin
            pkg_q   <= pkg_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.pkg_o       = pkg_q;
    assign bus.pkg_valid_o = (state_q == HOLD);
    assign bus.count_o     = count_q;
    assign bus.drop_o      = drop_q;

`ifdef RES_COLLECTOR_CSUM_EN
    logic [15:0] csum;

    res_collector_csum #(
        .RES_WIDTH (RES_WIDTH)
    ) u_csum (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clr_i    (release_pkg),
        .add_i    (accept),
        .word_i   (bus.res_i),
        .csum_o   (csum)
    );

    assign bus.csum_o = csum;
`endif

endmodule
